// File: rtl/feeder_pkg.sv
// Shared types and helpers for the systolic-array operand feeder.
// The read-address helper maps (step, element) of the stream onto the flat A|B buffer.
package feeder_pkg;

    typedef enum logic [3:0] {
        LOAD_S   = 4'b0001,
        STREAM_S = 4'b0010,
        WAIT_S   = 4'b0100,
        FLUSH_S  = 4'b1000
    } state_e;

    // Buffer layout: A row-major at [0, h*k), B row-major at [h*k, h*k+k*w).
    // Elements 0..w-1 of a step are B[step][*], the rest are A[*][step].
    function automatic int unsigned read_addr(
        input int unsigned step,
        input int unsigned element,
        input int unsigned h,
        input int unsigned w,
        input int unsigned k
    );
        int unsigned base;
        base = h * k;
        if (element < w) begin
            read_addr = base + step * w + element;
        end else begin
            read_addr = (element - w) * k + step;
        end
    endfunction

    // Bits needed to hold a counter whose largest value is terminal.
    function automatic int unsigned cnt_bits(input int unsigned terminal);
        cnt_bits = (terminal < 1) ? 1 : $clog2(terminal + 1);
    endfunction

endpackage

// File: rtl/operand_buffer.sv
// Flat operand store: one synchronous write port and one registered read port.
// A same-cycle write to the address being read is forwarded to the read register.
module operand_buffer
    import feeder_pkg::*;
#(
    parameter int width_p  = 32,
    parameter int words_p  = 8,
    parameter int addr_w_p = 3
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                en_i,
    input  logic                wr_en_i,
    input  logic [addr_w_p-1:0] wr_addr_i,
    input  logic [width_p-1:0]  wr_data_i,
    input  logic                rd_en_i,
    input  logic [addr_w_p-1:0] rd_addr_i,
    output logic [width_p-1:0]  rd_data_o
);

    logic [width_p-1:0] mem_q [words_p];
    logic [width_p-1:0] rd_data_q;
    logic               fwd;

    assign fwd = wr_en_i && (wr_addr_i == rd_addr_i);

    always_ff @(posedge clk_i) begin
        if (en_i && wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rd_data_q <= '0;
        end else if (en_i && rd_en_i) begin
            rd_data_q <= fwd ? wr_data_i : mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/matrix_feeder.sv
// Buffers operand matrices A and B, streams them to the systolic-array driver
// one word per step element, waits a drain time, then pulses the driver's flush.
module matrix_feeder
    import feeder_pkg::*;
#(
    parameter int width_p        = 32,
    parameter int array_width_p  = 2,
    parameter int array_height_p = 2,
    parameter int depth_p        = 2,
    parameter int drain_cycles_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               en_i,
    output logic               ready_o,
    input  logic               valid_i,
    input  logic [width_p-1:0] data_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [width_p-1:0] data_o,
    output logic               flush_o,
    output logic               busy_o
);

    localparam int unsigned WORDS    = array_height_p * depth_p + depth_p * array_width_p;
    localparam int unsigned STEP_LEN = array_width_p + array_height_p;
    localparam int unsigned LOAD_W   = cnt_bits(WORDS - 1);
    localparam int unsigned ADDR_W   = LOAD_W;
    localparam int unsigned ELEM_W   = cnt_bits(STEP_LEN - 1);
    localparam int unsigned STEP_W   = cnt_bits(depth_p - 1);
    localparam int unsigned DRAIN_W  = cnt_bits(drain_cycles_p - 1);

    localparam logic [LOAD_W-1:0]  LOAD_LAST  = LOAD_W'(WORDS - 1);
    localparam logic [ELEM_W-1:0]  ELEM_LAST  = ELEM_W'(STEP_LEN - 1);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(depth_p - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(drain_cycles_p - 1);

    state_e              state_q, state_d;
    logic [LOAD_W-1:0]   load_cnt_q, load_cnt_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [ELEM_W-1:0]   elem_q, elem_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic                load_xfer;
    logic [ADDR_W-1:0]   rd_addr;
    logic [width_p-1:0]  rd_data;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= LOAD_S;
            load_cnt_q <= '0;
            step_q     <= '0;
            elem_q     <= '0;
            drain_q    <= '0;
        end else if (en_i) begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            step_q     <= step_d;
            elem_q     <= elem_d;
            drain_q    <= drain_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        step_d     = step_q;
        elem_d     = elem_q;
        drain_d    = drain_q;
        ready_o    = 1'b0;
        valid_o    = 1'b0;
        flush_o    = 1'b0;
        load_xfer  = 1'b0;
        unique case (state_q)
            LOAD_S: begin
                ready_o   = 1'b1;
                load_xfer = valid_i && en_i;
                if (load_xfer) begin
                    if (load_cnt_q == LOAD_LAST) begin
                        load_cnt_d = '0;
                        state_d    = STREAM_S;
                    end else begin
                        load_cnt_d = load_cnt_q + LOAD_W'(1);
                    end
                end
            end
            STREAM_S: begin
                valid_o = 1'b1;
                if (ready_i && en_i) begin
                    if (elem_q == ELEM_LAST) begin
                        elem_d = '0;
                        if (step_q == STEP_LAST) begin
                            step_d  = '0;
                            state_d = WAIT_S;
                        end else begin
                            step_d = step_q + STEP_W'(1);
                        end
                    end else begin
                        elem_d = elem_q + ELEM_W'(1);
                    end
                end
            end
            WAIT_S: begin
                if (drain_q == DRAIN_LAST) begin
                    drain_d = '0;
                    state_d = FLUSH_S;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            FLUSH_S: begin
                flush_o = en_i;
                state_d = LOAD_S;
            end
            default: begin
                state_d = LOAD_S;
            end
        endcase
    end

    // Read from the address the counters will hold after this edge, so the
    // registered word is already in place when the counter points at it.
    assign rd_addr = ADDR_W'(read_addr(32'(step_d), 32'(elem_d), array_height_p,
                                       array_width_p, depth_p));

    operand_buffer #(
        .width_p  (width_p),
        .words_p  (WORDS),
        .addr_w_p (ADDR_W)
    ) u_buffer (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .en_i      (en_i),
        .wr_en_i   (load_xfer),
        .wr_addr_i (load_cnt_q),
        .wr_data_i (data_i),
        .rd_en_i   (1'b1),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    assign data_o = valid_o ? rd_data : '0;
    assign busy_o = !((state_q == LOAD_S) && (load_cnt_q == '0));

endmodule

// File: tb/tb_matrix_feeder.sv
// Self-checking bench for matrix_feeder: table vectors, randomized loads against a
// matrix-level reference model, reset mid-stream and a non-square instance.
module tb_matrix_feeder;

    localparam int H  = 2;
    localparam int WC = 2;
    localparam int K  = 2;
    localparam int D  = 8;
    localparam int NW = H * K + K * WC;
    localparam int SL = K * (WC + H);

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        en_i, ready_o, valid_i, valid_o, ready_i, flush_o, busy_o;
    logic [31:0] data_i, data_o;

    logic        en_n, ready_o_n, valid_n, valid_o_n, ready_n, flush_o_n, busy_o_n;
    logic [31:0] data_n, data_o_n;

    always #5 clk_i = ~clk_i;

    matrix_feeder #(
        .width_p(32), .array_width_p(WC), .array_height_p(H),
        .depth_p(K), .drain_cycles_p(D)
    ) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .en_i(en_i), .ready_o(ready_o),
        .valid_i(valid_i), .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i),
        .data_o(data_o), .flush_o(flush_o), .busy_o(busy_o)
    );

    matrix_feeder #(
        .width_p(32), .array_width_p(1), .array_height_p(3),
        .depth_p(2), .drain_cycles_p(1)
    ) dut_ns (
        .clk_i(clk_i), .reset_ni(reset_ni), .en_i(en_n), .ready_o(ready_o_n),
        .valid_i(valid_n), .data_i(data_n), .valid_o(valid_o_n), .ready_i(ready_n),
        .data_o(data_o_n), .flush_o(flush_o_n), .busy_o(busy_o_n)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] load_words[NW];
    int          n_xfer;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference model: rebuild A and B as matrices from load order, then emit
    // per step k the k-th row of B followed by the k-th column of A.
    function automatic void model_push(input int h, input int w, input int k);
        logic [31:0] am [4][4];
        logic [31:0] bm [4][4];
        for (int r = 0; r < h; r++)
            for (int c = 0; c < k; c++)
                am[r][c] = load_words[r * k + c];
        for (int r = 0; r < k; r++)
            for (int c = 0; c < w; c++)
                bm[r][c] = load_words[h * k + r * w + c];
        for (int s = 0; s < k; s++) begin
            for (int c = 0; c < w; c++) exp_q.push_back(bm[s][c]);
            for (int r = 0; r < h; r++) exp_q.push_back(am[r][s]);
        end
    endfunction

    always @(negedge clk_i) begin
        if (reset_ni && valid_o) begin
            if (prev_stall) check("stall_hold", data_o, prev_data);
            if (ready_i && en_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL extra_word: got %0d, expected no transfer", data_o);
                end else begin
                    check("stream_word", data_o, exp_q.pop_front());
                end
                n_xfer++;
            end
            prev_stall = !(ready_i && en_i);
            prev_data  = data_o;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- driver ----------------
    task automatic run_case(input logic [3:0] rdy_pat, input int gap_pct,
                            input bit en_drop, input int abort_at);
        int idx, cyc, flush_t, flush_n;
        bit low_ok;
        n_xfer = 0;
        idx = 0;
        cyc = 0;
        while (idx < NW && cyc < 400) begin
            valid_i = ($urandom_range(0, 99) >= gap_pct);
            data_i  = load_words[idx];
            en_i    = !(en_drop && cyc >= 3 && cyc < 6);
            ready_i = 1'($urandom_range(0, 1));
            check("ready_o_load", ready_o, 1);
            @(posedge clk_i);
            if (valid_i && en_i) idx++;
            #1;
            cyc++;
        end
        if (idx < NW) check("load_timeout", idx, NW);
        check("ready_o_drop", ready_o, 0);
        check("busy_o_stream", busy_o, 1);
        valid_i = 1'b1;
        data_i  = $urandom;

        cyc = 0;
        while (n_xfer < SL && cyc < 400) begin
            ready_i = rdy_pat[cyc % 4];
            en_i    = !(en_drop && cyc >= 2 && cyc < 5);
            @(posedge clk_i);
            #1;
            cyc++;
            if (abort_at != 0 && n_xfer == abort_at) return;
        end
        if (n_xfer < SL) check("stream_timeout", n_xfer, SL);

        flush_t = -1;
        flush_n = 0;
        low_ok  = 1'b1;
        for (int t = 0; t < D + 12; t++) begin
            en_i    = !(en_drop && ((t >= 2 && t < 5) || (t >= D + 3 && t < D + 6)));
            ready_i = 1'($urandom_range(0, 1));
            valid_i = (flush_t < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            data_i  = $urandom;
            @(negedge clk_i);
            if (valid_o) low_ok = 1'b0;
            if (flush_o) begin
                flush_n++;
                if (flush_t < 0) flush_t = t;
            end
            @(posedge clk_i);
            #1;
        end
        valid_i = 1'b0;
        en_i    = 1'b1;
        check("drain_valid_low", low_ok, 1);
        check("flush_count", flush_n, 1);
        check("flush_time", flush_t, en_drop ? D + 6 : D);
        check("ready_o_end", ready_o, 1);
        check("busy_o_end", busy_o, 0);
        check("sb_empty", exp_q.size(), 0);
    endtask

    typedef struct {
        string       name;
        logic [31:0] a [4];
        logic [31:0] b [4];
        logic [31:0] exp_s [8];
        logic [3:0]  rdy_pat;
        int          gap_pct;
        bit          en_drop;
    } vec_t;

    vec_t vecs [5];

    task automatic apply_vec(input int i, input int abort_at);
        for (int j = 0; j < 4; j++) begin
            load_words[j]     = vecs[i].a[j];
            load_words[j + 4] = vecs[i].b[j];
        end
        for (int j = 0; j < SL; j++) exp_q.push_back(vecs[i].exp_s[j]);
        run_case(vecs[i].rdy_pat, vecs[i].gap_pct, vecs[i].en_drop, abort_at);
    endtask

    logic [31:0] ns_exp [8];

    initial begin
        vecs[0] = '{name: "basic", a: '{1, 2, 3, 4}, b: '{5, 6, 7, 8},
                    exp_s: '{5, 6, 1, 3, 7, 8, 2, 4}, rdy_pat: 4'b1111, gap_pct: 0, en_drop: 0};
        vecs[1] = '{name: "backpressure", a: '{1, 2, 3, 4}, b: '{5, 6, 7, 8},
                    exp_s: '{5, 6, 1, 3, 7, 8, 2, 4}, rdy_pat: 4'b1001, gap_pct: 0, en_drop: 0};
        vecs[2] = '{name: "load_gaps", a: '{1, 2, 3, 4}, b: '{5, 6, 7, 8},
                    exp_s: '{5, 6, 1, 3, 7, 8, 2, 4}, rdy_pat: 4'b1111, gap_pct: 40, en_drop: 0};
        vecs[3] = '{name: "en_low", a: '{1, 2, 3, 4}, b: '{5, 6, 7, 8},
                    exp_s: '{5, 6, 1, 3, 7, 8, 2, 4}, rdy_pat: 4'b1111, gap_pct: 0, en_drop: 1};
        vecs[4] = '{name: "after_reset", a: '{9, 10, 11, 12}, b: '{13, 14, 15, 16},
                    exp_s: '{13, 14, 9, 11, 15, 16, 10, 12}, rdy_pat: 4'b1111, gap_pct: 0, en_drop: 0};
        ns_exp = '{7, 1, 3, 5, 8, 2, 4, 6};

        // ---------------- clock/reset ----------------
        reset_ni = 1'b0;
        en_i = 1'b1; valid_i = 1'b0; data_i = '0; ready_i = 1'b0;
        en_n = 1'b1; valid_n = 1'b0; data_n = '0; ready_n = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ready_o", ready_o, 1);
        check("rst_valid_o", valid_o, 0);
        check("rst_flush_o", flush_o, 0);
        check("rst_busy_o", busy_o, 0);
        check("rst_data_o", data_o, 0);
        reset_ni = 1'b1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 4; i++) begin
            $display("vector %0d: %s", i, vecs[i].name);
            apply_vec(i, 0);
        end

        // Reset after the third stream word, then a fresh load.
        apply_vec(0, 3);
        reset_ni = 1'b0;
        #1;
        check("midrst_valid_o", valid_o, 0);
        check("midrst_ready_o", ready_o, 1);
        check("midrst_data_o", data_o, 0);
        check("midrst_busy_o", busy_o, 0);
        check("midrst_flush_o", flush_o, 0);
        exp_q.delete();
        valid_i = 1'b0;
        en_i    = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        @(posedge clk_i);
        #1;
        apply_vec(4, 0);

        // Randomized loads checked against the matrix model.
        for (int it = 0; it < 15; it++) begin
            for (int j = 0; j < NW; j++) load_words[j] = $urandom;
            model_push(H, WC, K);
            run_case(4'($urandom_range(1, 15)), $urandom_range(0, 60),
                     1'($urandom_range(0, 1)), 0);
        end

        // Non-square instance: H=3, W=1, K=2, drain of one cycle.
        begin
            int got, cyc, last_x, fl_c, fl_n;
            valid_n = 1'b1;
            for (int i = 0; i < 8; i++) begin
                data_n = 32'(i + 1);
                check("ns_ready_load", ready_o_n, 1);
                @(posedge clk_i);
                #1;
            end
            valid_n = 1'b0;
            check("ns_ready_drop", ready_o_n, 0);
            got = 0; cyc = 0; last_x = -1; fl_c = -1; fl_n = 0;
            while (cyc < 100 && !(fl_c >= 0 && cyc > fl_c + 2)) begin
                ready_n = (got < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk_i);
                if (valid_o_n && ready_n) begin
                    if (got < 8) begin
                        check("ns_word", data_o_n, ns_exp[got]);
                        if (got == 7) last_x = cyc;
                    end else begin
                        check("ns_extra_word", got, 8);
                    end
                    got++;
                end
                if (flush_o_n) begin
                    fl_n++;
                    if (fl_c < 0) fl_c = cyc;
                end
                @(posedge clk_i);
                #1;
                cyc++;
            end
            check("ns_count", got, 8);
            check("ns_flush_count", fl_n, 1);
            check("ns_flush_time", fl_c - last_x, 2);
            check("ns_ready_end", ready_o_n, 1);
            check("ns_busy_end", busy_o_n, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
